// File: rtl/mul_seq_disp_pkg.sv
// Shared types and constants for the sequential multiplier with a scanned
// seven-segment display: FSM states, active-low glyphs (g..a) and helpers.
package mul_seq_disp_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_BCD,
      S_DONE
   } state_e;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   function automatic longint unsigned pow10(input int unsigned n);
      longint unsigned r;
      r = 64'd1;
      for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
      return r;
   endfunction

endpackage

// File: rtl/mul_seq_disp_if.sv
// Operand/result/display bundle of mul_seq_disp; master drives requests,
// slave (the multiplier) returns status, product and display lines.
interface mul_seq_disp_if #(
   parameter int unsigned W    = 4,
   parameter int unsigned NDIG = 3
);
   logic            start;
   logic [W-1:0]    a;
   logic [W-1:0]    b;
   logic            busy;
   logic            done;
   logic [2*W-1:0]  product;
   logic [6:0]      s;
   logic            dp;
   logic [NDIG-1:0] an;

   modport master (
      output start, a, b,
      input  busy, done, product, s, dp, an
   );

   modport slave (
      input  start, a, b,
      output busy, done, product, s, dp, an
   );
endinterface

// File: rtl/mul_seq_disp_seg7_dec.sv
// BCD digit to active-low seven-segment glyph (g..a); blank or non-decimal
// codes drive all segments off.
module seg7_dec
   import mul_seq_disp_pkg::*;
(
   input  logic [3:0] digit_i,
   input  logic       blank_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      if (!blank_i) begin
         case (digit_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/mul_seq_disp.sv
// Shift-add multiplier followed by double-dabble conversion; the committed
// product is shown on a free-running multiplexed seven-segment display.
module mul_seq_disp
   import mul_seq_disp_pkg::*;
#(
   parameter int unsigned W        = 4,
   parameter int unsigned NDIG     = 3,
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic          clk,
   input  logic          reset,
   mul_seq_disp_if.slave bus
);

   localparam int unsigned PW  = 2 * W;
   localparam int unsigned BW  = 4 * NDIG;
   localparam int unsigned CW  = $clog2(2 * W + 1);
   localparam int unsigned PSW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned IW  = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam longint unsigned MAXP = ((64'd1 << W) - 64'd1) * ((64'd1 << W) - 64'd1);

   if (W < 2 || W > 8) begin : g_bad_w
      $error("mul_seq_disp: W must be within 2..8");
   end
   if (pow10(NDIG) <= MAXP) begin : g_bad_ndig
      $error("mul_seq_disp: NDIG too small for the largest product");
   end
   if (SCAN_DIV < 1) begin : g_bad_div
      $error("mul_seq_disp: SCAN_DIV must be at least 1");
   end

   state_e           state_q, state_d;
   logic [PW-1:0]    mcand_q, mcand_d;
   logic [W-1:0]     mplier_q, mplier_d;
   logic [PW-1:0]    acc_q, acc_d;
   logic [PW-1:0]    bin_q, bin_d;
   logic [BW-1:0]    bcd_q, bcd_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [PW-1:0]    product_q, product_d;
   logic [BW-1:0]    disp_q, disp_d;
   logic [PSW-1:0]   presc_q, presc_d;
   logic [IW-1:0]    idx_q, idx_d;

   logic [BW-1:0]    adj;
   logic [BW+PW-1:0] sh;
   logic [NDIG-1:0]  blank_v;
   logic             nz;
   logic [3:0]       cur_dig;
   logic             cur_blank;
   logic [NDIG-1:0]  an_v;
   logic [6:0]       seg;

   always_ff @(posedge clk) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      bin_d     = bin_q;
      bcd_d     = bcd_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      disp_d    = disp_q;
      adj       = bcd_q;
      sh        = '0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               mcand_d  = PW'(bus.a);
               mplier_d = bus.b;
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = S_MUL;
            end
         end
         S_MUL: begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            // final partial sum is forwarded straight into the converter
            if (cnt_q == CW'(W - 1)) begin
               bin_d   = acc_d;
               bcd_d   = '0;
               cnt_d   = '0;
               state_d = S_BCD;
            end
         end
         S_BCD: begin
            for (int unsigned i = 0; i < NDIG; i++) begin
               if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end
            sh             = {adj, bin_q} << 1;
            {bcd_d, bin_d} = sh;
            cnt_d          = cnt_q + CW'(1);
            // results land on entry to DONE so they are valid alongside done
            if (cnt_q == CW'(PW - 1)) begin
               product_d = acc_q;
               disp_d    = sh[BW+PW-1:PW];
               state_d   = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      presc_d = presc_q + PSW'(1);
      idx_d   = idx_q;
      if (presc_q == PSW'(SCAN_DIV - 1)) begin
         presc_d = '0;
         idx_d   = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + IW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         bin_q     <= '0;
         bcd_q     <= '0;
         cnt_q     <= '0;
         product_q <= '0;
         disp_q    <= '0;
         presc_q   <= '0;
         idx_q     <= '0;
      end else begin
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         bin_q     <= bin_d;
         bcd_q     <= bcd_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
         disp_q    <= disp_d;
         presc_q   <= presc_d;
         idx_q     <= idx_d;
      end
   end

   // A digit is blanked when it and every digit above it are zero; digit 0 never is.
   always_comb begin
      blank_v   = '0;
      nz        = 1'b0;
      cur_dig   = '0;
      cur_blank = 1'b1;
      an_v      = '1;
      for (int unsigned k = NDIG; k > 0; k--) begin
         nz           = nz | (disp_q[4*(k-1) +: 4] != 4'd0);
         blank_v[k-1] = ~nz;
      end
      blank_v[0] = 1'b0;
      for (int unsigned i = 0; i < NDIG; i++) begin
         if (idx_q == IW'(i)) begin
            cur_dig   = disp_q[4*i +: 4];
            cur_blank = blank_v[i];
            an_v[i]   = 1'b0;
         end
      end
   end

   seg7_dec u_seg7_dec (
      .digit_i (cur_dig),
      .blank_i (cur_blank),
      .seg_o   (seg)
   );

   assign bus.busy    = (state_q != S_IDLE);
   assign bus.done    = (state_q == S_DONE);
   assign bus.product = product_q;
   assign bus.s       = seg;
   assign bus.dp      = 1'b1;
   assign bus.an      = an_v;

endmodule

// File: tb/tb_mul_seq_disp.sv
// Scoreboarded random/directed bench for mul_seq_disp (W=4, NDIG=3, SCAN_DIV=4).
module tb_mul_seq_disp;

   localparam int unsigned W        = 4;
   localparam int unsigned NDIG     = 3;
   localparam int unsigned SCAN_DIV = 4;
   localparam int unsigned LAT      = 3 * W + 1;

   logic clk;
   logic reset;

   mul_seq_disp_if #(.W(W), .NDIG(NDIG)) bus ();

   mul_seq_disp #(.W(W), .NDIG(NDIG), .SCAN_DIV(SCAN_DIV)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int unsigned checks   = 0;
   int unsigned failures = 0;

   // reference model state
   int unsigned exp_q[$];
   int unsigned busy_left = 0;
   int unsigned pending   = 0;
   int unsigned committed = 0;
   int unsigned m_presc   = 0;
   int unsigned m_idx     = 0;

   function automatic logic [6:0] glyph(input int unsigned d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [6:0] exp_seg(input int unsigned value, input int unsigned pos);
      int unsigned p10;
      p10 = 1;
      for (int unsigned k = 0; k < pos; k++) p10 = p10 * 10;
      if (pos > 0 && value < p10) return 7'b1111111;
      return glyph((value / p10) % 10);
   endfunction

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // model advances on the same edges the DUT samples
   always @(posedge clk) begin
      if (!reset) begin
         busy_left = 0;
         exp_q.delete();
         committed = 0;
         m_presc   = 0;
         m_idx     = 0;
      end else begin
         if (m_presc == SCAN_DIV - 1) begin
            m_presc = 0;
            m_idx   = (m_idx + 1) % NDIG;
         end else begin
            m_presc++;
         end
         if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 1) committed = pending;
         end else if (bus.start) begin
            pending   = int'(bus.a) * int'(bus.b);
            exp_q.push_back(pending);
            busy_left = LAT;
         end
      end
   end

   // monitor: samples on the falling edge, away from the active edge
   initial begin
      logic [NDIG-1:0] exp_an;
      int unsigned     e;
      @(posedge clk);
      forever begin
         @(negedge clk);
         chk("busy", bus.busy, (busy_left > 0) ? 1 : 0);
         chk("done", bus.done, (busy_left == 1) ? 1 : 0);
         chk("product_hold", bus.product, committed);
         chk("dp", bus.dp, 1);
         exp_an = '1;
         exp_an[m_idx] = 1'b0;
         chk("an", bus.an, exp_an);
         chk("seg", bus.s, exp_seg(committed, m_idx));
         if (bus.done) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL result: done with product %0d but nothing expected", bus.product);
            end else begin
               e = exp_q.pop_front();
               chk("result", bus.product, e);
            end
         end
      end
   end

   task automatic tick(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   task automatic issue(input int unsigned av, input int unsigned bv);
      bus.a     = W'(av);
      bus.b     = W'(bv);
      bus.start = 1'b1;
      tick(1);
      bus.start = 1'b0;
   endtask

   initial begin
      reset     = 1'b0;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      tick(3);
      reset = 1'b1;
      tick(14);

      issue(15, 15);
      tick(3);
      issue(1, 1);
      bus.a = 4'd3;
      bus.b = 4'd5;
      tick(20);

      issue(7, 8);
      tick(20);
      issue(0, 9);
      tick(20);

      issue(9, 9);
      tick(2);
      reset = 1'b0;
      tick(1);
      reset = 1'b1;
      tick(3);
      issue(6, 7);
      tick(20);

      issue(15, 15);
      tick(LAT - 1);
      issue(2, 3);
      tick(20);

      repeat (80) begin
         if ($urandom_range(0, 24) == 0) begin
            reset = 1'b0;
            tick(1);
            reset = 1'b1;
         end
         issue($urandom_range(0, 15), $urandom_range(0, 15));
         tick($urandom_range(0, 16));
      end
      tick(LAT + 4);

      chk("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mul_seq_disp.md
MUL_SEQ_DISP -- requirements
Module: mul_seq_disp

Interface
REQ-001 Parameter W, default 4, unsigned operand width (2..8).
REQ-002 Parameter NDIG, default 3, number of decimal display digits; elaboration SHALL fail unless 10^NDIG > (2^W-1)^2.
REQ-003 Parameter SCAN_DIV, default 50000, clock cycles each digit is driven (>=1).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 start  in  1  request to multiply a by b.
REQ-007 a  in  W  multiplicand, unsigned.
REQ-008 b  in  W  multiplier, unsigned.
REQ-009 busy  out  1  high while an operation is in progress.
REQ-010 done  out  1  one-cycle pulse when a result is committed.
REQ-011 product  out  2W  last committed product, binary.
REQ-012 s  out  7  segments g..a on s[6..0], active-low.
REQ-013 dp  out  1  decimal point, active-low; constant 1 (off).
REQ-014 an  out  NDIG  digit enables, active-low one-hot; an[0] is the least significant digit.

Function
REQ-015 The FSM SHALL have states IDLE, MUL, BCD and DONE.
REQ-016 In IDLE with start=1 (cycle t), a and b SHALL be latched, the accumulator cleared and the FSM moved to MUL; in IDLE with start=0, the FSM stays in IDLE.
REQ-017 MUL SHALL perform shift-add, one multiplier bit per cycle, for exactly W cycles, then move to BCD.
REQ-018 BCD SHALL run a shift-add-3 (double-dabble) conversion of the 2W-bit product into NDIG BCD digits over exactly 2W cycles, then move to DONE.
REQ-019 DONE SHALL last one cycle: the product and BCD digit registers are updated, done=1, and the FSM returns to IDLE.
REQ-020 Latency: done SHALL be high in cycle t+3W+1; for W=4, that is 13 cycles after acceptance.
REQ-021 busy SHALL be high in cycles t+1 through t+3W+1 inclusive, and low otherwise.
REQ-022 start SHALL be ignored while busy=1, including in DONE; the next start is accepted in IDLE at the earliest.
REQ-023 Changes to a and b after acceptance SHALL NOT affect the in-flight result.
REQ-024 product and the displayed digits SHALL hold their values between done pulses.
REQ-025 Multiplication is unsigned and exact in 2W bits; there is no overflow.
REQ-026 Scan: a prescaler SHALL count 0..SCAN_DIV-1; on wrap, the digit index advances modulo NDIG (0,1,..,NDIG-1,0).
REQ-027 The scan SHALL be free-running and independent of the FSM.
REQ-028 Exactly one an bit SHALL be low at any time.
REQ-029 Leading-zero blanking: a digit above the most significant nonzero digit SHALL drive s=7'b1111111.
REQ-030 Digit 0 SHALL always be shown, so a product of 0 displays "0".
REQ-031 Glyphs (active-low g..a): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.

Reset
REQ-032 When reset=0 at a rising edge, the FSM SHALL enter IDLE, and busy=0, done=0, product=0 and all BCD digits=0.
REQ-033 Reset SHALL clear the prescaler and set the digit index to 0, so an has only bit 0 low.
REQ-034 Reset SHALL take priority over start and over any in-flight operation; the aborted result is never committed and done does not pulse.
REQ-035 After reset, the display SHALL show "0" on digit 0, with all other digits blank.

Structure
REQ-036 Package mul_seq_disp_pkg SHALL hold the FSM state enum, the ten glyph constants and the BLANK constant (7'b1111111).
REQ-037 Segment decoding SHALL be one combinational sub-module, seg7_dec, mapping a 4-bit BCD digit plus a blank flag to s.
REQ-038 The multiplier, BCD converter, commit registers and scan logic SHALL reside in mul_seq_disp.

Verification (W=4, NDIG=3, SCAN_DIV=4)
REQ-039 a=15, b=15, start pulsed one cycle -> busy high for 13 cycles; done high in cycle 13; product=8'hE1; digits 2,2,5 displayed.
REQ-040 a=7, b=8 -> product=56; digit 2 blank (s=1111111); digit 1=0010010; digit 0=0000010.
REQ-041 a=0, b=9 -> product=0; digit 0=1000000; digits 1 and 2 blank.
REQ-042 Second start with a=1, b=1 during busy -> ignored; only one done pulse; product=225 from the first request.
REQ-043 reset=0 asserted for one cycle during MUL -> next cycle busy=0 and product=0; no done pulse; a following start completes normally.
REQ-044 Idle scan check -> an sequences 110, 101, 011, repeating, each value held for exactly 4 cycles.
